// File: rtl/spi_reg_cfg_engine.sv
// Table-driven SPI register writer for AD9516-class clock chips: walks NUM_REGS {addr,data} entries.
// Optional readback-verify with retry is enabled by defining SPI_CFG_READBACK_VERIFY_EN.
module spi_reg_cfg_engine #(
   parameter int NUM_REGS  = 64,
   parameter int ADDR_W    = 10,
   parameter int IDX_W     = 6,
   parameter int CLK_DIV   = 4,
   parameter int CS_GAP    = 8,
   parameter int MAX_RETRY = 3
) (
   input  logic              sys_clk_i,
   input  logic              rst_i,
   input  logic              start_i,
   output logic              busy_o,
   output logic              done_o,
   output logic              err_o,
   output logic [IDX_W-1:0]  fail_idx_o,
   output logic [IDX_W-1:0]  rom_addr_o,
   input  logic [ADDR_W+7:0] rom_data_i,
   output logic              spi_cs_n_o,
   output logic              spi_sclk_o,
   output logic              spi_mosi_o,
   input  logic              spi_miso_i
);

   localparam int DIV_W = (CLK_DIV < 2) ? 1 : $clog2(CLK_DIV);
   localparam int GAP_W = $clog2(CS_GAP + 1);

`ifdef SPI_CFG_READBACK_VERIFY_EN
   localparam int RTY_W = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
   typedef enum logic [2:0] {IDLE, FETCH, SHIFT, GAP, VERIFY, NEXT, DONE} state_t;
`else
   typedef enum logic [2:0] {IDLE, FETCH, SHIFT, GAP, NEXT, DONE} state_t;
`endif

   state_t             state_reg, state_next;
   logic               start_sync_reg, start_prev_reg;
   logic [IDX_W-1:0]   idx_reg;
   logic               fetch_wait_reg;
   logic [ADDR_W+7:0]  ent_reg;
   logic               cs_n_reg, sclk_reg;
   logic [23:0]        sh_reg;
   logic [DIV_W-1:0]   div_cnt_reg;
   logic [5:0]         edge_cnt_reg;
   logic [GAP_W-1:0]   gap_cnt_reg;
   logic [12:0]        addr13;

   logic start_edge, tick, gap_ok, launch, frame_end, last_idx, in_shift;

   genvar gi;
   generate
      for (gi = 0; gi < 13; gi++) begin : g_addr
         if (gi < ADDR_W) begin : g_bit
            assign addr13[gi] = ent_reg[8+gi];
         end else begin : g_pad
            assign addr13[gi] = 1'b0;
         end
      end
   endgenerate

   assign start_edge = start_sync_reg & ~start_prev_reg;
   assign tick       = (div_cnt_reg == DIV_W'(CLK_DIV - 1));
   assign gap_ok     = (gap_cnt_reg >= GAP_W'(CS_GAP - 1));
   assign frame_end  = ~cs_n_reg & tick & (edge_cnt_reg == 6'd48);
   assign last_idx   = (idx_reg == IDX_W'(NUM_REGS - 1));
`ifdef SPI_CFG_READBACK_VERIFY_EN
   assign in_shift   = (state_reg == SHIFT) || (state_reg == VERIFY);
`else
   assign in_shift   = (state_reg == SHIFT);
`endif
   // A shift state with CS still high is waiting out the inter-frame gap.
   assign launch     = in_shift & cs_n_reg & gap_ok;

`ifdef SPI_CFG_READBACK_VERIFY_EN
   logic [7:0]       rd_reg;
   logic             last_rd_reg;
   logic [RTY_W-1:0] retry_reg;
   logic             err_reg;
   logic [IDX_W-1:0] fail_idx_reg;
   logic             rd_match, retry_left;

   assign rd_match   = (rd_reg == ent_reg[7:0]);
   assign retry_left = (retry_reg < RTY_W'(MAX_RETRY));
   assign err_o      = err_reg;
   assign fail_idx_o = fail_idx_reg;
`else
   wire unused_ok = &{1'b0, spi_miso_i, (MAX_RETRY > 0)};
   assign err_o      = 1'b0;
   assign fail_idx_o = '0;
`endif

   always_ff @(posedge sys_clk_i) begin
      if (rst_i) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:   if (start_edge) state_next = FETCH;
         FETCH:  if (fetch_wait_reg) state_next = SHIFT;
         SHIFT:  if (frame_end) state_next = GAP;
`ifdef SPI_CFG_READBACK_VERIFY_EN
         VERIFY: if (frame_end) state_next = GAP;
         GAP: begin
            if (!last_rd_reg)     state_next = VERIFY;
            else if (rd_match)    state_next = NEXT;
            else if (retry_left)  state_next = SHIFT;
            else                  state_next = DONE;
         end
`else
         GAP:    state_next = NEXT;
`endif
         NEXT:   state_next = last_idx ? DONE : FETCH;
         DONE:   state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge sys_clk_i) begin
      if (rst_i) begin
         start_sync_reg <= 1'b0;
         start_prev_reg <= 1'b0;
         idx_reg        <= '0;
         fetch_wait_reg <= 1'b0;
         ent_reg        <= '0;
         cs_n_reg       <= 1'b1;
         sclk_reg       <= 1'b0;
         sh_reg         <= '0;
         div_cnt_reg    <= '0;
         edge_cnt_reg   <= '0;
         gap_cnt_reg    <= GAP_W'(CS_GAP);
`ifdef SPI_CFG_READBACK_VERIFY_EN
         rd_reg         <= '0;
         last_rd_reg    <= 1'b0;
         retry_reg      <= '0;
         err_reg        <= 1'b0;
         fail_idx_reg   <= '0;
`endif
      end else begin
         start_sync_reg <= start_i;
         start_prev_reg <= start_sync_reg;

         if (!cs_n_reg) begin
            gap_cnt_reg <= '0;
         end else if (gap_cnt_reg < GAP_W'(CS_GAP)) begin
            gap_cnt_reg <= gap_cnt_reg + 1'b1;
         end

         case (state_reg)
            IDLE: begin
               if (start_edge) begin
                  idx_reg        <= '0;
                  fetch_wait_reg <= 1'b0;
`ifdef SPI_CFG_READBACK_VERIFY_EN
                  err_reg        <= 1'b0;
                  fail_idx_reg   <= '0;
`endif
               end
            end
            FETCH: begin
               fetch_wait_reg <= ~fetch_wait_reg;
               if (fetch_wait_reg) begin
                  ent_reg <= rom_data_i;
`ifdef SPI_CFG_READBACK_VERIFY_EN
                  retry_reg <= '0;
`endif
               end
            end
`ifdef SPI_CFG_READBACK_VERIFY_EN
            GAP: begin
               if (last_rd_reg && !rd_match) begin
                  if (retry_left) begin
                     retry_reg <= retry_reg + 1'b1;
                  end else begin
                     err_reg      <= 1'b1;
                     fail_idx_reg <= idx_reg;
                  end
               end
            end
`endif
            NEXT: begin
               fetch_wait_reg <= 1'b0;
               if (!last_idx) idx_reg <= idx_reg + 1'b1;
            end
            default: ;
         endcase

         // Shared shift engine: edges 0..47 alternate rise/fall, edge 48 closes CS.
         if (launch) begin
            cs_n_reg     <= 1'b0;
            sclk_reg     <= 1'b0;
            div_cnt_reg  <= '0;
            edge_cnt_reg <= '0;
`ifdef SPI_CFG_READBACK_VERIFY_EN
            last_rd_reg  <= (state_reg == VERIFY);
            sh_reg       <= (state_reg == VERIFY) ? {1'b1, 2'b00, addr13, 8'h00}
                                                  : {1'b0, 2'b00, addr13, ent_reg[7:0]};
`else
            sh_reg       <= {1'b0, 2'b00, addr13, ent_reg[7:0]};
`endif
         end else if (!cs_n_reg) begin
            if (tick) begin
               div_cnt_reg <= '0;
               if (edge_cnt_reg == 6'd48) begin
                  cs_n_reg <= 1'b1;
               end else begin
                  sclk_reg     <= ~sclk_reg;
                  edge_cnt_reg <= edge_cnt_reg + 1'b1;
                  if (edge_cnt_reg[0]) begin
                     sh_reg <= {sh_reg[22:0], 1'b0};
                  end
`ifdef SPI_CFG_READBACK_VERIFY_EN
                  else if (edge_cnt_reg >= 6'd32) begin
                     rd_reg <= {rd_reg[6:0], spi_miso_i};
                  end
`endif
               end
            end else begin
               div_cnt_reg <= div_cnt_reg + 1'b1;
            end
         end
      end
   end

   assign rom_addr_o = idx_reg;
   assign spi_cs_n_o = cs_n_reg;
   assign spi_sclk_o = sclk_reg;
   assign spi_mosi_o = sh_reg[23];
   assign done_o     = (state_reg == DONE);
   assign busy_o     = (state_reg != IDLE) && (state_reg != DONE);

endmodule

// File: tb/tb_spi_reg_cfg_engine.sv
// Directed bench for spi_reg_cfg_engine: 4-entry table, SPI frame capture and timing monitor.
// Readback tests are built when SPI_CFG_READBACK_VERIFY_EN is defined.
module tb_spi_reg_cfg_engine;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic        busy, done, err, cs_n, sclk, mosi;
   logic        miso = 1'b0;
   logic [1:0]  fail_idx, rom_addr;
   logic [17:0] rom_data = '0;
   logic [17:0] tbl [4];

   int n_vec = 0;
   int n_err = 0;

   int          nframes = 0;
   logic [23:0] frames [16];
   int          lows   [16];
   int          rcnt   [16];
   int          gaps   [16];
   logic [23:0] cur = '0;
   int          rises = 0, low_cnt = 0, high_cnt = 0, done_cnt = 0, busy_at_done = 0;
   logic        cs_prev = 1'b1, sclk_prev = 1'b0;
   logic        bad_mode = 1'b0;
   logic [7:0]  rd_byte = '0;

   always #5 clk = ~clk;

   spi_reg_cfg_engine #(
      .NUM_REGS(4), .ADDR_W(10), .IDX_W(2), .CLK_DIV(4), .CS_GAP(8), .MAX_RETRY(3)
   ) dut (
      .sys_clk_i(clk), .rst_i(rst), .start_i(start), .busy_o(busy), .done_o(done),
      .err_o(err), .fail_idx_o(fail_idx), .rom_addr_o(rom_addr), .rom_data_i(rom_data),
      .spi_cs_n_o(cs_n), .spi_sclk_o(sclk), .spi_mosi_o(mosi), .spi_miso_i(miso)
   );

   always @(posedge clk) rom_data <= tbl[rom_addr];

   function automatic logic [7:0] rd_value(input logic [12:0] a);
      for (int i = 0; i < 4; i++) begin
         if ({3'b000, tbl[i][17:8]} == a) return (bad_mode && i == 2) ? 8'hFF : tbl[i][7:0];
      end
      return 8'h00;
   endfunction

   // Frame monitor and SDO model, sampled mid-cycle.
   always @(negedge clk) begin
      if (done) begin
         done_cnt = done_cnt + 1;
         if (busy) busy_at_done = busy_at_done + 1;
      end
      if (cs_n) begin
         if (!cs_prev) begin
            if (nframes < 16) begin
               frames[nframes] = cur;
               lows[nframes]   = low_cnt;
               rcnt[nframes]   = rises;
            end
            nframes  = nframes + 1;
            high_cnt = 1;
         end else begin
            high_cnt = high_cnt + 1;
         end
         miso = 1'b0;
      end else begin
         if (cs_prev) begin
            if (nframes > 0 && nframes <= 16) gaps[nframes-1] = high_cnt;
            cur = '0; rises = 0; low_cnt = 0;
         end
         low_cnt = low_cnt + 1;
         if (sclk && !sclk_prev) begin
            cur   = {cur[22:0], mosi};
            rises = rises + 1;
         end
         if (rises == 16) rd_byte = cur[15] ? rd_value(cur[12:0]) : 8'h00;
         if (rises >= 16 && rises < 24) miso = rd_byte[7 - (rises - 16)];
         else miso = 1'b0;
      end
      cs_prev   = cs_n;
      sclk_prev = sclk;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec = n_vec + 1;
      if (got !== exp) begin
         n_err = n_err + 1;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end else begin
         $display("ok   %s: 0x%0h", tag, got);
      end
   endtask

   task automatic pulse_start();
      start = 1'b1;
      repeat (3) @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_done(input int budget);
      int base = done_cnt;
      int n = 0;
      while (done_cnt == base && n < budget) begin
         @(negedge clk);
         n++;
      end
      chk("run_done_in_budget", 32'(done_cnt != base), 32'd1);
      repeat (20) @(negedge clk);
   endtask

   task automatic clear_mon();
      nframes = 0;
      done_cnt = 0;
      busy_at_done = 0;
   endtask

   int cnt;

   initial begin
      tbl[0] = {10'h000, 8'h99};
      tbl[1] = {10'h010, 8'h7C};
      tbl[2] = {10'h1E1, 8'h02};
      tbl[3] = {10'h232, 8'h01};

      repeat (4) @(negedge clk);
      chk("rst_busy",     32'(busy),     32'd0);
      chk("rst_done",     32'(done),     32'd0);
      chk("rst_err",      32'(err),      32'd0);
      chk("rst_fail_idx", 32'(fail_idx), 32'd0);
      chk("rst_rom_addr", 32'(rom_addr), 32'd0);
      chk("rst_cs_n",     32'(cs_n),     32'd1);
      chk("rst_sclk",     32'(sclk),     32'd0);
      chk("rst_mosi",     32'(mosi),     32'd0);
      rst = 1'b0;
      repeat (4) @(negedge clk);

`ifndef SPI_CFG_READBACK_VERIFY_EN
      // T1/T2: one full run
      clear_mon();
      pulse_start();
      chk("t1_busy_running", 32'(busy), 32'd1);
      wait_done(5000);
      chk("t1_done_pulses", 32'(done_cnt), 32'd1);
      chk("t1_busy_at_done", 32'(busy_at_done), 32'd0);
      chk("t1_busy_after", 32'(busy), 32'd0);
      chk("t1_nframes", 32'(nframes), 32'd4);
      chk("t1_frame0", 32'(frames[0]), 32'h000099);
      chk("t1_frame1", 32'(frames[1]), 32'h00107C);
      chk("t1_frame2", 32'(frames[2]), 32'h01E102);
      chk("t1_frame3", 32'(frames[3]), 32'h023201);
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("t2_cs_low_%0d", i), 32'(lows[i]), 32'd196);
         chk($sformatf("t2_sclk_rises_%0d", i), 32'(rcnt[i]), 32'd24);
      end
      for (int i = 0; i < 3; i++) chk($sformatf("t2_cs_gap_%0d", i), 32'(gaps[i]), 32'd8);

      // T3: extra edge mid-run plus a long held level
      clear_mon();
      start = 1'b1;
      repeat (300) @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      start = 1'b1;
      repeat (700) @(negedge clk);
      start = 1'b0;
      repeat (300) @(negedge clk);
      chk("t3_done_pulses", 32'(done_cnt), 32'd1);
      chk("t3_nframes", 32'(nframes), 32'd4);
      chk("t3_busy_after", 32'(busy), 32'd0);

      // T4: reset during frame 2 bit 10
      clear_mon();
      pulse_start();
      cnt = 0;
      while (!(nframes == 1 && !cs_n && rises == 11) && cnt < 5000) begin
         @(negedge clk);
         cnt++;
      end
      chk("t4_reached_bit10", 32'(cnt < 5000), 32'd1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("t4_cs_n_after_rst", 32'(cs_n), 32'd1);
      chk("t4_sclk_after_rst", 32'(sclk), 32'd0);
      chk("t4_busy_after_rst", 32'(busy), 32'd0);
      repeat (10) @(negedge clk);
      clear_mon();
      pulse_start();
      wait_done(5000);
      chk("t4_nframes", 32'(nframes), 32'd4);
      chk("t4_restart_frame0", 32'(frames[0]), 32'h000099);
      chk("t4_restart_frame3", 32'(frames[3]), 32'h023201);
      chk("t4_err", 32'(err), 32'd0);
`else
      // T5: readback matches
      clear_mon();
      bad_mode = 1'b0;
      pulse_start();
      wait_done(20000);
      chk("t5_nframes", 32'(nframes), 32'd8);
      chk("t5_err", 32'(err), 32'd0);
      chk("t5_frame0", 32'(frames[0]), 32'h000099);
      chk("t5_frame1_read", 32'(frames[1]), 32'h800000);
      chk("t5_frame6", 32'(frames[6]), 32'h023201);
      chk("t5_frame7_read", 32'(frames[7]), 32'h823200);
      chk("t5_cs_low_read", 32'(lows[1]), 32'd196);
      chk("t5_gap_wr_rd", 32'(gaps[0]), 32'd8);
      chk("t5_done_pulses", 32'(done_cnt), 32'd1);

      // T6: entry 2 never verifies
      clear_mon();
      bad_mode = 1'b1;
      pulse_start();
      wait_done(30000);
      chk("t6_nframes", 32'(nframes), 32'd12);
      chk("t6_err", 32'(err), 32'd1);
      chk("t6_fail_idx", 32'(fail_idx), 32'd2);
      cnt = 0;
      for (int i = 0; i < 12; i++) if (frames[i] == 24'h01E102) cnt++;
      chk("t6_entry2_writes", 32'(cnt), 32'd4);
      cnt = 0;
      for (int i = 0; i < 12; i++) if (frames[i][20:8] == 13'h232) cnt++;
      chk("t6_entry3_frames", 32'(cnt), 32'd0);
      chk("t6_busy_after", 32'(busy), 32'd0);

      clear_mon();
      bad_mode = 1'b0;
      pulse_start();
      repeat (5) @(negedge clk);
      chk("t6_err_cleared_by_start", 32'(err), 32'd0);
      wait_done(20000);
      chk("t6_rerun_err", 32'(err), 32'd0);
      chk("t6_rerun_nframes", 32'(nframes), 32'd8);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
